moisture_trigger: RTL and testbench

MOISTURE_TRIGGER -- requirements
Module: moisture_trigger

---
 rtl/riego_pkg.sv | 34 +++
 rtl/moisture_avg4.sv | 53 +++++
 rtl/moisture_trigger.sv | 127 ++++++++++++
 tb/tb_moisture_trigger.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riego_pkg.sv
// Shared FSM encoding, default thresholds and pump-speed helper for the
// moisture-driven watering trigger.
package riego_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR  = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WATERING = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  localparam logic [7:0]  DRY_THRESH_DEF      = 8'd100;
  localparam logic [7:0]  WET_THRESH_DEF      = 8'd160;
  localparam logic [31:0] ACK_TIMEOUT_DEF     = 32'd1_000_000;
  localparam logic [31:0] COOLDOWN_CYCLES_DEF = 32'd50_000_000;

  localparam logic [9:0]  SPEED_BASE = 10'd128;
  localparam logic [9:0]  SPEED_MAX  = 10'd255;

  // Drier soil asks for a faster pump: 128 + 2*(dry - avg), clipped to 8 bits.
  // Only called while avg < dry, so the difference never goes negative.
  function automatic logic [7:0] calc_speed(input logic [7:0] avg_in,
                                            input logic [7:0] dry_in);
    logic [9:0] diff;
    logic [9:0] raw;
    diff = {2'b00, dry_in} - {2'b00, avg_in};
    raw  = SPEED_BASE + {diff[8:0], 1'b0};
    if (raw > SPEED_MAX) begin
      return 8'hFF;
    end
    return raw[7:0];
  endfunction

endpackage

// File: rtl/moisture_avg4.sv
// Four-sample moving average of the moisture ADC stream, with a fill counter
// so the average is only trusted once the window is full.
module moisture_avg4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic [7:0] avg,
  output logic       avg_valid
);

  logic [3:0][7:0] buf_q, buf_d;
  logic [9:0]      sum_q, sum_d;
  logic [7:0]      avg_q, avg_d;
  logic [2:0]      fill_q, fill_d;

  always_comb begin
    buf_d  = buf_q;
    sum_d  = sum_q;
    avg_d  = avg_q;
    fill_d = fill_q;
    if (valid) begin
      buf_d[0] = data;
      for (int i = 1; i < 4; i++) begin
        buf_d[i] = buf_q[i-1];
      end
      // Running sum: add the newcomer, drop the sample falling out of the window.
      sum_d = sum_q + {2'b00, data} - {2'b00, buf_q[3]};
      avg_d = sum_d[9:2];
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      sum_q  <= '0;
      avg_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      sum_q  <= sum_d;
      avg_q  <= avg_d;
      fill_q <= fill_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = (fill_q == 3'd4);

endmodule

// File: rtl/moisture_trigger.sv
// Watering trigger: averages soil moisture, requests the pump when dry,
// aborts when wet, and rests for a cooldown period after each watering.
module moisture_trigger
  import riego_pkg::*;
#(
  parameter logic [7:0]  DRY_THRESH      = DRY_THRESH_DEF,
  parameter logic [7:0]  WET_THRESH      = WET_THRESH_DEF,
  parameter logic [31:0] ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
  parameter logic [31:0] COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  input  logic       pump_busy,
  output logic       start_req,
  output logic [7:0] target_speed,
  output logic       abort,
  output logic       fault,
  output logic [7:0] avg_moisture,
  output logic [1:0] state_o
);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        fault_q, fault_d;
  logic [7:0]  target_q, target_d;
  logic        abort_done_q, abort_done_d;
  logic        ready_q, ready_d;
  logic        abort_now;

  logic        accept;
  logic [7:0]  avg;
  logic        avg_valid;

  assign accept = sample_valid & ready_q;

  moisture_avg4 u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (accept),
    .data      (sample_data),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fault_d      = fault_q;
    target_d     = target_q;
    abort_done_d = abort_done_q;
    abort_now    = 1'b0;
    case (state_q)
      ST_MONITOR: begin
        if (avg_valid && (avg < DRY_THRESH)) begin
          state_d  = ST_REQUEST;
          timer_d  = '0;
          target_d = calc_speed(avg, DRY_THRESH);
        end
      end
      ST_REQUEST: begin
        if (pump_busy) begin
          state_d      = ST_WATERING;
          abort_done_d = 1'b0;
        end else if (timer_q >= ACK_TIMEOUT - 32'd1) begin
          fault_d = 1'b1;
          state_d = ST_MONITOR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_WATERING: begin
        // Only the first wet reading of a watering raises abort.
        if (!abort_done_q && avg_valid && (avg >= WET_THRESH)) begin
          abort_now    = 1'b1;
          abort_done_d = 1'b1;
        end
        if (!pump_busy) begin
          state_d = ST_COOLDOWN;
          timer_d = '0;
        end
      end
      ST_COOLDOWN: begin
        if (timer_q >= COOLDOWN_CYCLES - 32'd1) begin
          state_d = ST_MONITOR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_MONITOR;
      end
    endcase
    // Registered from the next state so ready lines up exactly with COOLDOWN.
    ready_d = (state_d != ST_COOLDOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_MONITOR;
      timer_q      <= '0;
      fault_q      <= 1'b0;
      target_q     <= '0;
      abort_done_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fault_q      <= fault_d;
      target_q     <= target_d;
      abort_done_q <= abort_done_d;
      ready_q      <= ready_d;
    end
  end

  // Decoded from the async-reset state register, so reset drops it at once.
  assign start_req    = (state_q == ST_REQUEST);
  assign abort        = abort_now;
  assign fault        = fault_q;
  assign target_speed = target_q;
  assign avg_moisture = avg;
  assign state_o      = state_q;
  assign sample_ready = ready_q;

endmodule

// File: tb/tb_moisture_trigger.sv
// Directed test of moisture_trigger with short timeout and cooldown.
module tb_moisture_trigger;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic       pump_busy;
  logic       start_req;
  logic [7:0] target_speed;
  logic       abort;
  logic       fault;
  logic [7:0] avg_moisture;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  moisture_trigger #(
    .DRY_THRESH      (8'd100),
    .WET_THRESH      (8'd160),
    .ACK_TIMEOUT     (32'd8),
    .COOLDOWN_CYCLES (32'd16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .pump_busy    (pump_busy),
    .start_req    (start_req),
    .target_speed (target_speed),
    .abort        (abort),
    .fault        (fault),
    .avg_moisture (avg_moisture),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
    $display("sample %0d sent: avg=%0d state=%0d ready=%0d", d, avg_moisture, state_o, sample_ready);
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    pump_busy    = 1'b0;
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    pump_busy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL reset_start_req: got %0b expected 0", start_req); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", sample_ready); end
    checks++; if (avg_moisture !== 8'd0) begin errors++; $display("FAIL reset_avg: got %0d expected 0", avg_moisture); end
    checks++; if (target_speed !== 8'd0) begin errors++; $display("FAIL reset_target: got %0d expected 0", target_speed); end
    checks++; if ({abort, fault} !== 2'b00) begin errors++; $display("FAIL reset_abort_fault: got %b expected 00", {abort, fault}); end
    rst_n = 1'b1;
    tick();
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b expected 1", sample_ready); end
  endtask

  task automatic test_wet_hold();
    apply_reset();
    repeat (4) send_sample(8'd200);
    checks++; if (avg_moisture !== 8'd200) begin errors++; $display("FAIL wet_avg: got %0d expected 200", avg_moisture); end
    repeat (3) tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL wet_state: got %0d expected 0", state_o); end
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL wet_start_req: got %0b expected 0", start_req); end
  endtask

  task automatic test_dry_cycle();
    int cnt;
    apply_reset();
    repeat (3) send_sample(8'd60);
    checks++; if (avg_moisture !== 8'd45) begin errors++; $display("FAIL dry_partial_avg: got %0d expected 45", avg_moisture); end
    send_sample(8'd60);
    checks++; if (avg_moisture !== 8'd60) begin errors++; $display("FAIL dry_avg: got %0d expected 60", avg_moisture); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL dry_state_pre: got %0d expected 0", state_o); end
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL dry_request: got %0d expected 1", state_o); end
    checks++; if (target_speed !== 8'd208) begin errors++; $display("FAIL dry_target: got %0d expected 208", target_speed); end
    checks++; if (start_req !== 1'b1) begin errors++; $display("FAIL dry_start_req: got %0b expected 1", start_req); end
    pump_busy = 1'b1;
    tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dry_watering: got %0d expected 2", state_o); end
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL dry_start_drop: got %0b expected 0", start_req); end
    tick();
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL dry_no_abort: got %0b expected 0", abort); end
    pump_busy = 1'b0;
    tick();
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL dry_cooldown: got %0d expected 3", state_o); end
    cnt = 0;
    while (state_o == 2'd3 && cnt < 40) begin
      checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL cooldown_ready: got %0b expected 0 at cycle %0d", sample_ready, cnt); end
      tick();
      cnt++;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL cooldown_length: got %0d expected 16", cnt); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL cooldown_exit: got %0d expected 0", state_o); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL cooldown_ready_back: got %0b expected 1", sample_ready); end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (4) send_sample(8'd60);
    tick();
    checks++; if (start_req !== 1'b1) begin errors++; $display("FAIL to_start_req: got %0b expected 1", start_req); end
    repeat (7) tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL to_still_request: got %0d expected 1", state_o); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_fault_early: got %0b expected 0", fault); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %0b expected 1", fault); end
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL to_start_drop: got %0b expected 0", start_req); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL to_state: got %0d expected 0", state_o); end
    repeat (2) tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault_sticky: got %0b expected 1", fault); end
    checks++; if (start_req !== 1'b1) begin errors++; $display("FAIL to_rerequest: got %0b expected 1", start_req); end
    rst_n = 1'b0;
    #2;
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL async_start_drop: got %0b expected 0", start_req); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL async_fault_clear: got %0b expected 0", fault); end
  endtask

  task automatic test_saturation_abort();
    int pulses;
    int first_idx;
    apply_reset();
    repeat (4) send_sample(8'd0);
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL sat_request: got %0d expected 1", state_o); end
    checks++; if (target_speed !== 8'd255) begin errors++; $display("FAIL sat_target: got %0d expected 255", target_speed); end
    pump_busy = 1'b1;
    tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL sat_watering: got %0d expected 2", state_o); end
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) send_sample(8'd170);
      else tick();
      if (abort === 1'b1) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", pulses); end
    checks++; if (first_idx != 3) begin errors++; $display("FAIL abort_position: got %0d expected 3", first_idx); end
    checks++; if (avg_moisture !== 8'd170) begin errors++; $display("FAIL abort_avg: got %0d expected 170", avg_moisture); end
  endtask

  task automatic test_reset_in_watering();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL rw_pre_state: got %0d expected 2", state_o); end
    rst_n = 1'b0;
    #2;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rw_state: got %0d expected 0", state_o); end
    checks++; if (avg_moisture !== 8'd0) begin errors++; $display("FAIL rw_avg: got %0d expected 0", avg_moisture); end
    checks++; if (target_speed !== 8'd0) begin errors++; $display("FAIL rw_target: got %0d expected 0", target_speed); end
    checks++; if ({start_req, abort, fault, sample_ready} !== 4'b0000) begin errors++; $display("FAIL rw_flags: got %b expected 0000", {start_req, abort, fault, sample_ready}); end
    pump_busy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    repeat (3) send_sample(8'd0);
    repeat (2) tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rw_refill_wait: got %0d expected 0", state_o); end
    send_sample(8'd0);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rw_fourth_pre: got %0d expected 0", state_o); end
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL rw_request: got %0d expected 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_wet_hold();
    test_dry_cycle();
    test_timeout();
    test_saturation_abort();
    test_reset_in_watering();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
